// File: rtl/center_mean_accum.sv
// Cluster-centre update engine: accumulates point coordinates, then divides each sum by the count.
// Define CENTER_ROUND_EN to round the mean to nearest (ties up) instead of truncating.
module center_mean_accum #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              center_clk,
   input  logic              center_rst_n,
   input  logic              pt_valid,
   input  logic [DATA_W-1:0] pt_x,
   input  logic [DATA_W-1:0] pt_y,
   output logic              pt_ready,
   input  logic              finish,
   output logic              center_valid,
   input  logic              center_ready,
   output logic [DATA_W-1:0] center_x,
   output logic [DATA_W-1:0] center_y,
   output logic [CNT_W-1:0]  center_cnt,
   output logic              center_empty
);

   localparam int unsigned SUM_W  = DATA_W + CNT_W;
   localparam int unsigned STEP_W = $clog2(SUM_W + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SUM_W - 1);

   typedef enum logic [1:0] {StAcc, StDiv, StOut} state_e;

   state_e              state_q;
   logic [SUM_W-1:0]    sum_x_q, sum_y_q;
   logic [SUM_W-1:0]    rem_x_q, rem_y_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [STEP_W-1:0]   step_q;
   logic                center_valid_q, center_empty_q;
   logic [DATA_W-1:0]   center_x_q, center_y_q;
   logic [CNT_W-1:0]    center_cnt_q;

   logic                accept;
   logic [SUM_W-1:0]    acc_x, acc_y, dvd_x, dvd_y;
   logic [CNT_W-1:0]    cnt_acc;
   logic [2*SUM_W-1:0]  step_x, step_y;

   // One restoring step; the sum register doubles as dividend and collects quotient bits.
   function automatic logic [2*SUM_W-1:0] div_step(input logic [SUM_W-1:0] rem,
                                                   input logic [SUM_W-1:0] dvd,
                                                   input logic [CNT_W-1:0] dvs);
      logic [SUM_W-1:0] r_sh;
      logic             q;
      r_sh = {rem[SUM_W-2:0], dvd[SUM_W-1]};
      q    = (r_sh >= SUM_W'(dvs));
      if (q) begin
         r_sh = r_sh - SUM_W'(dvs);
      end
      return {r_sh, dvd[SUM_W-2:0], q};
   endfunction

   assign pt_ready = (state_q == StAcc) && (cnt_q != CNT_MAX);
   assign accept   = pt_valid && pt_ready;
   assign acc_x    = sum_x_q + (accept ? SUM_W'(pt_x) : '0);
   assign acc_y    = sum_y_q + (accept ? SUM_W'(pt_y) : '0);
   assign cnt_acc  = cnt_q + CNT_W'(accept);

`ifdef CENTER_ROUND_EN
   assign dvd_x = acc_x + SUM_W'(cnt_acc >> 1);
   assign dvd_y = acc_y + SUM_W'(cnt_acc >> 1);
`else
   assign dvd_x = acc_x;
   assign dvd_y = acc_y;
`endif

   always_comb begin
      step_x = div_step(rem_x_q, sum_x_q, cnt_q);
      step_y = div_step(rem_y_q, sum_y_q, cnt_q);
   end

   always_ff @(posedge center_clk or negedge center_rst_n) begin
      if (!center_rst_n) begin
         state_q        <= StAcc;
         sum_x_q        <= '0;
         sum_y_q        <= '0;
         rem_x_q        <= '0;
         rem_y_q        <= '0;
         cnt_q          <= '0;
         step_q         <= '0;
         center_valid_q <= 1'b0;
         center_empty_q <= 1'b0;
         center_x_q     <= '0;
         center_y_q     <= '0;
         center_cnt_q   <= '0;
      end else begin
         unique case (state_q)
            StAcc: begin
               if (accept) begin
                  sum_x_q <= acc_x;
                  sum_y_q <= acc_y;
                  cnt_q   <= cnt_acc;
               end
               if (finish) begin
                  if (cnt_acc == '0) begin
                     state_q        <= StOut;
                     center_valid_q <= 1'b1;
                     center_empty_q <= 1'b1;
                     center_x_q     <= '0;
                     center_y_q     <= '0;
                     center_cnt_q   <= '0;
                  end else begin
                     state_q <= StDiv;
                     sum_x_q <= dvd_x;
                     sum_y_q <= dvd_y;
                     rem_x_q <= '0;
                     rem_y_q <= '0;
                     step_q  <= '0;
                  end
               end
            end
            StDiv: begin
               sum_x_q <= step_x[SUM_W-1:0];
               sum_y_q <= step_y[SUM_W-1:0];
               rem_x_q <= step_x[2*SUM_W-1:SUM_W];
               rem_y_q <= step_y[2*SUM_W-1:SUM_W];
               if (step_q == LAST_STEP) begin
                  state_q        <= StOut;
                  center_valid_q <= 1'b1;
                  center_empty_q <= 1'b0;
                  // Mean never exceeds the largest coordinate, so the low bits hold it exactly.
                  center_x_q     <= step_x[DATA_W-1:0];
                  center_y_q     <= step_y[DATA_W-1:0];
                  center_cnt_q   <= cnt_q;
               end else begin
                  step_q <= step_q + 1'b1;
               end
            end
            StOut: begin
               if (center_ready) begin
                  state_q        <= StAcc;
                  center_valid_q <= 1'b0;
                  sum_x_q        <= '0;
                  sum_y_q        <= '0;
                  rem_x_q        <= '0;
                  rem_y_q        <= '0;
                  cnt_q          <= '0;
               end
            end
            default: state_q <= StAcc;
         endcase
      end
   end

   assign center_valid = center_valid_q;
   assign center_empty = center_empty_q;
   assign center_x     = center_x_q;
   assign center_y     = center_y_q;
   assign center_cnt   = center_cnt_q;

endmodule

// File: tb/tb_center_mean_accum.sv
// Self-checking bench for center_mean_accum: vector table, corner sequences and random clusters.
module tb_center_mean_accum;

   localparam int unsigned DW  = 32;
   localparam int unsigned CW  = 16;
   localparam int unsigned SW  = DW + CW;
   localparam int unsigned SDW = 8;
   localparam int unsigned SCW = 2;
   localparam int unsigned SSW = SDW + SCW;
`ifdef CENTER_ROUND_EN
   localparam bit ROUND = 1'b1;
`else
   localparam bit ROUND = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   always #5 clk = ~clk;

   logic           pt_valid = 1'b0, finish = 1'b0, center_ready = 1'b0;
   logic [DW-1:0]  pt_x = '0, pt_y = '0;
   logic           pt_ready, center_valid, center_empty;
   logic [DW-1:0]  center_x, center_y;
   logic [CW-1:0]  center_cnt;

   logic           s_pt_valid = 1'b0, s_finish = 1'b0, s_center_ready = 1'b0;
   logic [SDW-1:0] s_pt_x = '0, s_pt_y = '0;
   logic           s_pt_ready, s_center_valid, s_center_empty;
   logic [SDW-1:0] s_center_x, s_center_y;
   logic [SCW-1:0] s_center_cnt;

   center_mean_accum #(.DATA_W(DW), .CNT_W(CW)) dut (
      .center_clk(clk), .center_rst_n(rst_n), .pt_valid(pt_valid), .pt_x(pt_x), .pt_y(pt_y),
      .pt_ready(pt_ready), .finish(finish), .center_valid(center_valid),
      .center_ready(center_ready), .center_x(center_x), .center_y(center_y),
      .center_cnt(center_cnt), .center_empty(center_empty)
   );

   center_mean_accum #(.DATA_W(SDW), .CNT_W(SCW)) dut_small (
      .center_clk(clk), .center_rst_n(rst_n), .pt_valid(s_pt_valid), .pt_x(s_pt_x),
      .pt_y(s_pt_y), .pt_ready(s_pt_ready), .finish(s_finish), .center_valid(s_center_valid),
      .center_ready(s_center_ready), .center_x(s_center_x), .center_y(s_center_y),
      .center_cnt(s_center_cnt), .center_empty(s_center_empty)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference mean: plain arithmetic on the full sums.
   function automatic logic [63:0] ref_mean(input logic [63:0] sum, input int n);
      logic [63:0] bias;
      bias = ROUND ? 64'(n / 2) : 64'd0;
      return (sum + bias) / 64'(n);
   endfunction

   typedef struct {
      int          n;
      logic [31:0] xs[8];
      logic [31:0] ys[8];
      logic [31:0] ex;
      logic [31:0] ey;
      logic [15:0] ec;
      bit          ee;
      int          hold;
   } vec_t;

   vec_t tbl[6];

   task automatic run_cluster(input string tag, input int n, input logic [31:0] xs[8],
                              input logic [31:0] ys[8], input bit fin_last, input int hold,
                              input logic [31:0] ex, input logic [31:0] ey,
                              input logic [15:0] ec, input bit ee);
      int          lat;
      bit          stable;
      for (int i = 0; i < n; i++) begin
         pt_valid = 1'b1;
         pt_x     = xs[i];
         pt_y     = ys[i];
         finish   = fin_last && (i == n - 1);
         @(negedge clk);
         pt_valid = 1'b0;
         finish   = 1'b0;
      end
      if (!fin_last || n == 0) begin
         finish = 1'b1;
         @(negedge clk);
         finish = 1'b0;
      end
      lat = 1;
      while (!center_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check({tag, " latency"}, 64'(lat), (n == 0) ? 64'd1 : 64'(1 + SW));
      check({tag, " center_x"}, 64'(center_x), 64'(ex));
      check({tag, " center_y"}, 64'(center_y), 64'(ey));
      check({tag, " center_cnt"}, 64'(center_cnt), 64'(ec));
      check({tag, " center_empty"}, 64'(center_empty), 64'(ee));
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (!center_valid || pt_ready || center_x !== ex || center_y !== ey ||
             center_cnt !== ec || center_empty !== ee) stable = 1'b0;
      end
      if (hold > 0) check({tag, " hold stable"}, 64'(stable), 64'd1);
      center_ready = 1'b1;
      @(negedge clk);
      center_ready = 1'b0;
      check({tag, " valid after handshake"}, 64'(center_valid), 64'd0);
      check({tag, " pt_ready after handshake"}, 64'(pt_ready), 64'd1);
   endtask

   initial begin
      logic [31:0] xs[8];
      logic [31:0] ys[8];
      logic [63:0] sx, sy;
      int          n, lat;
      bit          seen;

      foreach (tbl[i]) begin
         tbl[i].n = 0; tbl[i].hold = 0; tbl[i].ee = 1'b0;
         foreach (tbl[i].xs[j]) begin tbl[i].xs[j] = '0; tbl[i].ys[j] = '0; end
      end
      tbl[0].n = 2; tbl[0].xs[0] = 10; tbl[0].ys[0] = 20; tbl[0].xs[1] = 20; tbl[0].ys[1] = 41;
      tbl[0].ex = 15; tbl[0].ey = ROUND ? 31 : 30; tbl[0].ec = 2; tbl[0].hold = 10;
      tbl[1].n = 1; tbl[1].xs[0] = 7; tbl[1].ys[0] = 7; tbl[1].ex = 7; tbl[1].ey = 7; tbl[1].ec = 1;
      tbl[2].n = 0; tbl[2].ex = 0; tbl[2].ey = 0; tbl[2].ec = 0; tbl[2].ee = 1'b1; tbl[2].hold = 2;
      tbl[3].n = 4; tbl[3].ex = 32'hFFFF_FFFF; tbl[3].ey = 0; tbl[3].ec = 4;
      for (int j = 0; j < 4; j++) tbl[3].xs[j] = 32'hFFFF_FFFF;
      tbl[4].n = 3; tbl[4].xs[0] = 1; tbl[4].ys[0] = 2; tbl[4].xs[1] = 2; tbl[4].ys[1] = 2;
      tbl[4].xs[2] = 2; tbl[4].ys[2] = 3; tbl[4].ex = ROUND ? 2 : 1; tbl[4].ey = 2; tbl[4].ec = 3;
      tbl[5].n = 4; tbl[5].xs[0] = 100; tbl[5].ys[3] = 1; tbl[5].ex = 25; tbl[5].ey = 0;
      tbl[5].ec = 4;

      // Reset state
      repeat (2) @(negedge clk);
      check("reset pt_ready", 64'(pt_ready), 64'd1);
      check("reset center_valid", 64'(center_valid), 64'd0);
      check("reset center_x", 64'(center_x), 64'd0);
      check("reset center_cnt", 64'(center_cnt), 64'd0);
      check("reset center_empty", 64'(center_empty), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         run_cluster($sformatf("tbl%0d", i), tbl[i].n, tbl[i].xs, tbl[i].ys, 1'b1, tbl[i].hold,
                     tbl[i].ex, tbl[i].ey, tbl[i].ec, tbl[i].ee);
      end

      // Reset in the middle of a division
      xs[0] = 1000; ys[0] = 3; xs[1] = 2000; ys[1] = 5;
      pt_valid = 1'b1; pt_x = xs[0]; pt_y = ys[0];
      @(negedge clk);
      pt_x = xs[1]; pt_y = ys[1]; finish = 1'b1;
      @(negedge clk);
      pt_valid = 1'b0; finish = 1'b0;
      repeat (19) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midreset center_valid", 64'(center_valid), 64'd0);
      check("midreset center_x", 64'(center_x), 64'd0);
      check("midreset center_y", 64'(center_y), 64'd0);
      check("midreset center_cnt", 64'(center_cnt), 64'd0);
      check("midreset center_empty", 64'(center_empty), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("midreset pt_ready", 64'(pt_ready), 64'd1);
      seen = 1'b0;
      repeat (70) begin
         @(negedge clk);
         if (center_valid) seen = 1'b1;
      end
      check("midreset no valid", 64'(seen), 64'd0);

      // Small counter: fourth point refused, finish proceeds while the point is held
      xs[0] = 10; ys[0] = 1; xs[1] = 20; ys[1] = 2; xs[2] = 30; ys[2] = 4; xs[3] = 200; ys[3] = 200;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("small pt_ready %0d", i), 64'(s_pt_ready), (i < 3) ? 64'd1 : 64'd0);
         s_pt_valid = 1'b1; s_pt_x = xs[i][SDW-1:0]; s_pt_y = ys[i][SDW-1:0];
         s_finish = (i == 3);
         @(negedge clk);
      end
      s_pt_valid = 1'b0; s_finish = 1'b0;
      lat = 1;
      while (!s_center_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check("small latency", 64'(lat), 64'(1 + SSW));
      check("small center_cnt", 64'(s_center_cnt), 64'd3);
      check("small center_x", 64'(s_center_x), 64'd20);
      check("small center_y", 64'(s_center_y), 64'd2);
      check("small center_empty", 64'(s_center_empty), 64'd0);
      s_center_ready = 1'b1;
      @(negedge clk);
      s_center_ready = 1'b0;
      check("small pt_ready after", 64'(s_pt_ready), 64'd1);

      // Random clusters against the reference model
      for (int r = 0; r < 25; r++) begin
         n = $urandom_range(0, 6);
         sx = '0; sy = '0;
         for (int j = 0; j < 8; j++) begin
            xs[j] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 1000));
            ys[j] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 1000));
            if (j < n) begin
               sx += 64'(xs[j]);
               sy += 64'(ys[j]);
            end
         end
         run_cluster($sformatf("rnd%0d", r), n, xs, ys, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 3),
                     (n == 0) ? 32'd0 : 32'(ref_mean(sx, n)),
                     (n == 0) ? 32'd0 : 32'(ref_mean(sy, n)),
                     16'(n), n == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/center_mean_accum.md
Name: center_mean_accum

Overview:
- Cluster-centre update engine for the K-means datapath.
- Accumulates the (X,Y) coordinates of every point assigned to one cluster and counts them.
- On a finish request it divides each sum by the count with a sequential restoring divider, then presents the new centre.
- The new centre is the value the distance subtractor later consumes as the centre operand.

Parameters:
- DATA_W, 32, width of each unsigned coordinate (X, Y, centre outputs).
- CNT_W, 16, width of the point counter; max points per cluster = 2^CNT_W-1.
- SUM_W, DATA_W+CNT_W (derived, not overridable), width of the sum and remainder registers.

Ports:
- center_clk  in  1  single clock; all state updates on its rising edge.
- center_rst_n  in  1  asynchronous active-low reset.
- pt_valid  in  1  point offered.
- pt_x  in  DATA_W  point X coordinate, unsigned.
- pt_y  in  DATA_W  point Y coordinate, unsigned.
- pt_ready  out  1  block accepts a point this cycle.
- finish  in  1  single-cycle pulse; closes the current cluster.
- center_valid  out  1  centre result available.
- center_ready  in  1  consumer takes the result.
- center_x  out  DATA_W  mean X.
- center_y  out  DATA_W  mean Y.
- center_cnt  out  CNT_W  number of points averaged.
- center_empty  out  1  cluster had zero points.

Behaviour:
- Reset value of every register is 0, except the state register (ACC), so pt_ready=1 after reset. center_valid, center_x, center_y, center_cnt and center_empty all reset to 0.
- An asynchronous reset asserted in any state, including mid-division, aborts the operation and discards sums, count and any pending result.
- States: ACC, DIV, OUT.
- ACC:
  - pt_ready = 1 while count < 2^CNT_W-1, otherwise 0 (full). A point offered while full is not accepted and is held by the producer.
  - On pt_valid&pt_ready: sumX += pt_x, sumY += pt_y (SUM_W bits, no overflow possible), count += 1.
  - finish in the same cycle as an accepted point: that point is included in the result.
  - finish with resulting count = 0: go to OUT next cycle with center_empty=1, centre=0, cnt=0.
  - finish with resulting count > 0: load the dividends (sum plus any rounding bias), clear the remainders, go to DIV.
  - finish while pt_valid is high but the block is full: the point is not accepted; finish proceeds.
- DIV:
  - pt_ready=0; finish is ignored.
  - Two restoring dividers run in parallel, X and Y, sharing divisor = count.
  - Each produces one quotient bit per cycle, MSB first, for exactly SUM_W cycles; then go to OUT.
  - Quotient is truncated to DATA_W bits. It always fits because the mean is ≤ 2^DATA_W-1.
- OUT:
  - center_valid=1. center_x, center_y, center_cnt and center_empty are registered and stable until the handshake.
  - On center_valid&center_ready: clear sums and count, center_valid←0, return to ACC. pt_ready rises the following cycle.
- Latency: finish in cycle T with non-zero count gives center_valid high in cycle T+1+SUM_W (49 at defaults). With empty count it is high in cycle T+1.
- Outputs are driven from registers only; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: CENTER_ROUND_EN.
- Defined: at the ACC→DIV transition each dividend becomes sum + (count>>1), so the result is rounded to nearest with ties rounded up. There is no added latency and no overflow, since the biased sum is < 2^SUM_W.
- Undefined: the quotient is truncated (floor). Bias logic is absent.

Test Plan:
- Points (10,20),(20,41), finish pulsed in the same cycle as the second point → after 49 cycles center_x=15, center_y=30 (61/2 floored, or 31 with CENTER_ROUND_EN), center_cnt=2, center_empty=0.
- finish with no points → next cycle center_valid=1, center_empty=1, center_x=center_y=0, center_cnt=0.
- Four points (0xFFFFFFFF,0) → center_x=0xFFFFFFFF, center_y=0, center_cnt=4, under both macro settings.
- center_ready held low 10 cycles after center_valid → outputs stable and pt_ready=0 throughout; center_ready=1 → next cycle ACC, pt_ready=1. A new cluster (7,7) with finish → centre (7,7), cnt=1, showing the previous sums were cleared.
- CNT_W=2: offer 4 points → pt_ready drops after 3 accepted; finish → center_cnt=3 and the mean of the first three points only.
- center_rst_n pulsed low at cycle 20 of DIV → all outputs 0 immediately, pt_ready=1 after release, and no center_valid appears afterwards.
